md5_chunk_padder: RTL and testbench

//  Byte-stream front end for Md5Core: packs message bytes into 512-bit wordChunk blocks and applies MD5 padding.

---
 rtl/md5_chunk_padder.sv | 176 +++++++++++++++++
 tb/tb_md5_chunk_padder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_chunk_padder.sv
// Byte-stream to 512-bit MD5 chunk packer with MD5 padding (0x80, zero fill, 64-bit LE bit length).
// Optional MD5_PAD_ABORT_EN adds a synchronous abort input that discards the current message.
module md5_chunk_padder #(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic [7:0]   inData,
    input  logic         inValid,
    input  logic         inLast,
    input  logic         inEmpty,
    output logic         inReady,
    output logic [511:0] outChunk,
    output logic         outValid,
    output logic         outFirst,
    output logic         outLast,
    input  logic         outReady,
`ifdef MD5_PAD_ABORT_EN
    input  logic         abort,
`endif
    output logic [1:0]   dbgState
);

    // Handshakes: a byte moves when inValid & inReady at a rising edge; a chunk moves
    // when outValid & outReady at a rising edge. While outValid is held without
    // outReady, outChunk/outFirst/outLast do not change and inReady stays low.
    typedef enum logic [1:0] {FILL, PAD, EMIT, PAD2} state_t;

    state_t           state_q, state_n;
    logic [6:0]       idx_q, idx_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [511:0]     buf_q, buf_n;
    logic             valid_q, valid_n;
    logic             first_q, first_n;
    logic             last_q, last_n;
    logic             ready_q, ready_n;
    logic             closed_q, closed_n;
    logic             fresh_q, fresh_n;
    logic [63:0]      bit_len;
    logic             byte_xfer;
    logic             chunk_xfer;

    assign bit_len    = 64'({cnt_q, 3'b000});
    assign byte_xfer  = inValid & ready_q;
    assign chunk_xfer = valid_q & outReady;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= FILL;
            idx_q    <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            ready_q  <= 1'b0;
            closed_q <= 1'b0;
            fresh_q  <= 1'b1;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
            buf_q    <= buf_n;
            valid_q  <= valid_n;
            first_q  <= first_n;
            last_q   <= last_n;
            ready_q  <= ready_n;
            closed_q <= closed_n;
            fresh_q  <= fresh_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        cnt_n    = cnt_q;
        buf_n    = buf_q;
        valid_n  = valid_q;
        first_n  = first_q;
        last_n   = last_q;
        closed_n = closed_q;
        fresh_n  = fresh_q;
        case (state_q)
            FILL: begin
                if (byte_xfer) begin
                    if (inLast && inEmpty) begin
                        state_n  = PAD;
                        closed_n = 1'b1;
                    end else begin
                        buf_n[{idx_q[5:0], 3'b000} +: 8] = inData;
                        idx_n = idx_q + 7'd1;
                        cnt_n = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (inLast) begin
                            state_n  = PAD;
                            closed_n = 1'b1;
                        end else if (idx_q == 7'd63) begin
                            state_n = EMIT;
                            valid_n = 1'b1;
                            first_n = fresh_q;
                            last_n  = 1'b0;
                        end
                    end
                end
            end
            PAD: begin
                // idx_q is the first free byte; 64 means the data filled the chunk exactly
                for (int i = 0; i < 64; i++) begin
                    if (i == int'(idx_q))
                        buf_n[i*8 +: 8] = 8'h80;
                    else if (i > int'(idx_q))
                        buf_n[i*8 +: 8] = 8'h00;
                end
                if (idx_q <= 7'd55) begin
                    buf_n[511:448] = bit_len;
                    last_n = 1'b1;
                end else begin
                    last_n = 1'b0;
                end
                first_n = fresh_q;
                valid_n = 1'b1;
                state_n = EMIT;
            end
            EMIT: begin
                if (chunk_xfer) begin
                    valid_n = 1'b0;
                    first_n = 1'b0;
                    fresh_n = last_q;
                    if (last_q || !closed_q) begin
                        state_n  = FILL;
                        idx_n    = '0;
                        buf_n    = '0;
                        last_n   = 1'b0;
                        closed_n = 1'b0;
                        if (last_q)
                            cnt_n = '0;
                    end else begin
                        state_n = PAD2;
                    end
                end
            end
            PAD2: begin
                buf_n = '0;
                if (idx_q == 7'd64)
                    buf_n[7:0] = 8'h80;
                buf_n[511:448] = bit_len;
                first_n = 1'b0;
                last_n  = 1'b1;
                valid_n = 1'b1;
                state_n = EMIT;
            end
            default: state_n = FILL;
        endcase
`ifdef MD5_PAD_ABORT_EN
        if (abort) begin
            state_n  = FILL;
            idx_n    = '0;
            cnt_n    = '0;
            buf_n    = '0;
            valid_n  = 1'b0;
            first_n  = 1'b0;
            last_n   = 1'b0;
            closed_n = 1'b0;
            fresh_n  = 1'b1;
        end
`endif
        ready_n = (state_n == FILL);
    end

    assign inReady  = ready_q;
    assign outChunk = buf_q;
    assign outValid = valid_q;
    assign outFirst = first_q;
    assign outLast  = last_q;
    assign dbgState = state_q;

endmodule

// File: tb/tb_md5_chunk_padder.sv
// Directed bench for md5_chunk_padder: an independent MD5 padding model feeds a chunk scoreboard.
// Also exercises MD5_PAD_ABORT_EN when that macro is defined.
module tb_md5_chunk_padder;

    logic         clk;
    logic         resetN;
    logic [7:0]   inData;
    logic         inValid;
    logic         inLast;
    logic         inEmpty;
    logic         inReady;
    logic [511:0] outChunk;
    logic         outValid;
    logic         outFirst;
    logic         outLast;
    logic         outReady;
    logic [1:0]   dbgState;
`ifdef MD5_PAD_ABORT_EN
    logic         abort;
`endif

    int errors = 0;
    int checks = 0;

    logic [513:0] exp_q[$];
    logic [7:0]   msg[$];
    logic [513:0] mon_e;
    logic [511:0] t1c;

    md5_chunk_padder dut (
        .clk      (clk),
        .resetN   (resetN),
        .inData   (inData),
        .inValid  (inValid),
        .inLast   (inLast),
        .inEmpty  (inEmpty),
        .inReady  (inReady),
        .outChunk (outChunk),
        .outValid (outValid),
        .outFirst (outFirst),
        .outLast  (outLast),
        .outReady (outReady),
`ifdef MD5_PAD_ABORT_EN
        .abort    (abort),
`endif
        .dbgState (dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [513:0] obs, input logic [513:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: compare each chunk on the cycle before its transfer edge
    always @(negedge clk) begin
        if (resetN === 1'b1 && outValid === 1'b1 && outReady === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_chunk: observed=%0h expected=none", outChunk);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("chunk", {outFirst, outLast, outChunk}, mon_e);
            end
        end
    end

    // reference MD5 padding of msg into expected {first,last,chunk} entries
    task automatic load_model();
        logic [7:0]   pad[$];
        logic [63:0]  bl;
        logic [511:0] ch;
        int           n;
        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bl = 64'(msg.size()) << 3;
        for (int k = 0; k < 8; k++) pad.push_back(bl[8*k +: 8]);
        n = pad.size() / 64;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 64; i++) ch[8*i +: 8] = pad[64*c + i];
            exp_q.push_back({(c == 0), (c == n - 1), ch});
        end
    endtask

    // driver tasks: callers sit 1 time unit after a rising edge
    task automatic send_byte(input logic [7:0] d, input logic last, input logic empty);
        int n = 0;
        inData  = d;
        inValid = 1'b1;
        inLast  = last;
        inEmpty = empty;
        while (inReady !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 200) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed inReady=%b expected=1", inReady);
        end
        @(posedge clk); #1;
        inValid = 1'b0;
        inLast  = 1'b0;
        inEmpty = 1'b0;
    endtask

    task automatic drive_msg(input logic trail_empty);
        if (msg.size() == 0) begin
            send_byte(8'h00, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < msg.size(); i++)
                send_byte(msg[i], (i == msg.size() - 1) && !trail_empty, 1'b0);
            if (trail_empty) send_byte(8'h00, 1'b1, 1'b1);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 514'(exp_q.size()), 514'd0);
        @(posedge clk); #1;
    endtask

    task automatic send_msg(input string tag, input logic trail_empty);
        load_model();
        drive_msg(trail_empty);
        drain(tag);
    endtask

    task automatic fill_msg(input int len, input logic [7:0] v);
        msg.delete();
        repeat (len) msg.push_back(v);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_chunk"}, outChunk, 0);
        check({tag, "_valid"}, outValid, 0);
        check({tag, "_first"}, outFirst, 0);
        check({tag, "_last"},  outLast, 0);
        check({tag, "_ready"}, inReady, 0);
    endtask

    // "A": chunk appears on the second edge counting the capture edge
    task automatic run_t1(input string tag);
        msg.delete();
        msg.push_back(8'h41);
        load_model();
        send_byte(8'h41, 1'b1, 1'b0);
        check({tag, "_valid_lag"}, outValid, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, outValid, 1);
        check({tag, "_chunk"}, outChunk, t1c);
        check({tag, "_first_last"}, {outFirst, outLast}, 2'b11);
        drain({tag, "_drain"});
    endtask

    initial begin
        string s;
        int    n;
        t1c = '0;
        t1c[7:0]     = 8'h41;
        t1c[15:8]    = 8'h80;
        t1c[455:448] = 8'h08;
        inData   = 8'h00;
        inValid  = 1'b0;
        inLast   = 1'b0;
        inEmpty  = 1'b0;
        outReady = 1'b1;
        resetN   = 1'b0;
`ifdef MD5_PAD_ABORT_EN
        abort    = 1'b0;
`endif
        @(posedge clk); #1;
        check_reset("reset");
        check("reset_state", dbgState, 0);
        resetN = 1'b1;
        #1;
        check("ready_after_release", inReady, 0);
        @(posedge clk); #1;
        check("ready_first_edge", inReady, 1);

        run_t1("t1");

        msg.delete();
        send_msg("t2_empty", 1'b0);

        fill_msg(56, 8'h61);
        send_msg("t4_56", 1'b0);
        fill_msg(64, 8'h61);
        send_msg("t4_64", 1'b0);
        fill_msg(55, 8'h62);
        send_msg("len55", 1'b0);
        fill_msg(63, 8'h63);
        send_msg("len63", 1'b0);
        fill_msg(3, 8'h64);
        send_msg("trail_empty_3", 1'b1);
        fill_msg(64, 8'h65);
        send_msg("trail_empty_64", 1'b1);
        for (int r = 0; r < 3; r++) begin
            msg.delete();
            repeat ($urandom_range(1, 130)) msg.push_back(8'($urandom_range(0, 255)));
            send_msg("random", 1'b0);
        end

        // T3 under backpressure
        s = "The quick brown fox jumps over the lazy dog.";
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
        outReady = 1'b0;
        load_model();
        drive_msg(1'b0);
        n = 0;
        while (outValid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t3_valid", outValid, 1);
        check("t3_len", outChunk[463:448], 16'h0160);
        check("t3_pad", outChunk[359:352], 8'h80);
        for (int c = 0; c < 10; c++) begin
            check("t5_hold_chunk", outChunk, exp_q[0][511:0]);
            check("t5_hold_ready", inReady, 0);
            check("t5_hold_valid", outValid, 1);
            @(posedge clk); #1;
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        check("t5_ready_after", inReady, 1);
        check("t5_valid_after", outValid, 0);
        drain("t5_drain");

        // T6: asynchronous reset mid-message
        for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        resetN = 1'b0;
        #1;
        check_reset("t6_reset");
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;
        run_t1("t6_t1");

`ifdef MD5_PAD_ABORT_EN
        for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_chunk", outChunk, 0);
        check("abort_valid", outValid, 0);
        check("abort_ready", inReady, 1);
        run_t1("abort_t1");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
